// File: rtl/gsim_mat_mem_server_pkg.sv
// Shared types and sizing for the matrix row memory server.
package gsim_mat_mem_server_pkg;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_SERVE = 2'd1,
      ST_DRAIN = 2'd2
   } srv_state_t;

   localparam int ROW_W         = 256;
   localparam int ROWS_PER_MAT  = 17;
   localparam int MAX_MATS      = 32;
   localparam int WORD_W        = 32;
   localparam int WORDS_PER_ROW = ROW_W / WORD_W;
   localparam int ROW_AW        = 10;
   localparam int WORD_AW       = 3;
   localparam int LANE_W        = 16;

endpackage

// File: rtl/gsim_mat_mem_server_row_sram.sv
// Row storage: DEPTH x 256-bit array, 32-bit word writes, one-cycle registered read.
// Out-of-range rows read as zero; the array itself is never reset.
module gsim_row_sram
   import gsim_mat_mem_server_pkg::*;
#(
   parameter int DEPTH = ROWS_PER_MAT * MAX_MATS
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [ROW_AW-1:0]   wr_row,
   input  logic [WORD_AW-1:0]  wr_word,
   input  logic [WORD_W-1:0]   wr_data,
   input  logic                rd_en,
   input  logic [ROW_AW-1:0]   rd_row,
   output logic [ROW_W-1:0]    rd_data
);

   localparam logic [ROW_AW:0] DEPTH_L = (ROW_AW+1)'(DEPTH);

   logic [ROW_W-1:0] mem [DEPTH];
   logic             rd_hit;

   assign rd_hit = ({1'b0, rd_row} < DEPTH_L);

   always_ff @(posedge clk) begin
      for (int w = 0; w < WORDS_PER_ROW; w++) begin
         if (wr_en && (wr_word == WORD_AW'(w)))
            mem[wr_row][w*WORD_W +: WORD_W] <= wr_data;
      end
   end

   // Output register only moves on a read, so it holds the last returned row.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         rd_data <= '0;
      else if (rd_en)
         rd_data <= rd_hit ? mem[rd_row] : '0;
   end

endmodule

// File: rtl/gsim_mat_mem_server.sv
// Matrix row memory server: host loads 32-bit words in LOAD, solver reads 256-bit rows in SERVE.
// Reads are fully pipelined with a fixed RD_LAT; DRAIN lets in-flight reads finish before LOAD.
module gsim_mat_mem_server
   import gsim_mat_mem_server_pkg::*;
#(
   parameter int DEPTH        = ROWS_PER_MAT * MAX_MATS,
   parameter int RD_LAT       = 2,
   parameter int STALL_PERIOD = 0
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_ld_mode,
   input  logic              i_ld_wen,
   input  logic [12:0]       i_ld_addr,
   input  logic [31:0]       i_ld_data,
   output logic              o_ld_err,
   input  logic              i_mem_rreq,
   input  logic [9:0]        i_mem_addr,
   output logic              o_mem_rrdy,
   output logic [ROW_W-1:0]  o_mem_dout,
   output logic              o_mem_dout_vld,
   output logic              o_busy
);

   localparam int              ACC_W   = (STALL_PERIOD > 0) ? $clog2(STALL_PERIOD + 1) : 1;
   localparam logic [ROW_AW:0] DEPTH_L = (ROW_AW+1)'(DEPTH);

   srv_state_t          state, state_nxt;
   logic [2:0]          inflight, inflight_nxt;
   logic [ACC_W-1:0]    acc_cnt;
   logic                bubble;
   logic                accept;
   logic                wr_ok;
   logic [ROW_AW-1:0]   ld_row;
   logic [WORD_AW-1:0]  ld_word;
   logic [RD_LAT-1:0]   vld_sr;
   logic [ROW_W-1:0]    sram_q;

   assign ld_row  = i_ld_addr[12:3];
   assign ld_word = i_ld_addr[2:0];

   // The mode-switch cycle is still LOAD but already rejects writes.
   assign wr_ok = i_ld_wen && (state == ST_LOAD) && i_ld_mode
                  && ({1'b0, ld_row} < DEPTH_L);

   assign bubble     = (STALL_PERIOD != 0) && (acc_cnt == ACC_W'(STALL_PERIOD));
   assign o_mem_rrdy = (state == ST_SERVE) && !i_ld_mode && !bubble;
   assign accept     = i_mem_rreq && o_mem_rrdy;

   always_comb begin
      inflight_nxt = inflight;
      case ({accept, o_mem_dout_vld})
         2'b10:   inflight_nxt = inflight + 3'd1;
         2'b01:   inflight_nxt = inflight - 3'd1;
         default: inflight_nxt = inflight;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_LOAD:  if (!i_ld_mode) state_nxt = ST_SERVE;
         ST_SERVE: if (i_ld_mode)  state_nxt = ST_DRAIN;
         ST_DRAIN: if (inflight_nxt == 3'd0) state_nxt = ST_LOAD;
         default:  state_nxt = ST_LOAD;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state    <= ST_LOAD;
         inflight <= 3'd0;
         o_ld_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         inflight <= inflight_nxt;
         o_ld_err <= i_ld_wen && !wr_ok;
      end
   end

   // Accept count survives DRAIN/LOAD so the bubble cadence resumes where it left off.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         acc_cnt <= '0;
      end else if ((STALL_PERIOD != 0) && (state == ST_SERVE)) begin
         if (bubble)
            acc_cnt <= '0;
         else if (accept)
            acc_cnt <= acc_cnt + ACC_W'(1);
      end
   end

   assign o_busy = (inflight != 3'd0);

   gsim_row_sram #(
      .DEPTH (DEPTH)
   ) u_row_sram (
      .clk     (i_clk),
      .reset   (i_reset),
      .wr_en   (wr_ok),
      .wr_row  (ld_row),
      .wr_word (ld_word),
      .wr_data (i_ld_data),
      .rd_en   (accept),
      .rd_row  (i_mem_addr),
      .rd_data (sram_q)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         vld_sr <= '0;
      end else begin
         vld_sr[0] <= accept;
         for (int k = 1; k < RD_LAT; k++)
            vld_sr[k] <= vld_sr[k-1];
      end
   end

   assign o_mem_dout_vld = vld_sr[RD_LAT-1];

   generate
      if (RD_LAT == 1) begin : g_lat1
         assign o_mem_dout = sram_q;
      end else begin : g_latn
         logic [ROW_W-1:0] dat_sr [1:RD_LAT-1];

         // Each stage only advances with valid data, so the tail holds the last row.
         always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
               for (int k = 1; k < RD_LAT; k++)
                  dat_sr[k] <= '0;
            end else begin
               if (vld_sr[0])
                  dat_sr[1] <= sram_q;
               for (int k = 2; k < RD_LAT; k++)
                  if (vld_sr[k-1])
                     dat_sr[k] <= dat_sr[k-1];
            end
         end

         assign o_mem_dout = dat_sr[RD_LAT-1];
      end
   endgenerate

endmodule

// File: tb/tb_gsim_mat_mem_server.sv
// Directed bench for gsim_mat_mem_server: one instance without bubbles, one with STALL_PERIOD=4.
module tb_gsim_mat_mem_server;

   logic         clk;
   // instance A: RD_LAT=2, no bubbles
   logic         rst, ld_mode, ld_wen, rreq;
   logic [12:0]  ld_addr;
   logic [31:0]  ld_data;
   logic [9:0]   maddr;
   logic         ld_err, rrdy, vld, busy;
   logic [255:0] dout;
   // instance B: RD_LAT=2, STALL_PERIOD=4
   logic         b_rst, b_ld_mode, b_ld_wen, b_rreq;
   logic [12:0]  b_ld_addr;
   logic [31:0]  b_ld_data;
   logic [9:0]   b_maddr;
   logic         b_ld_err, b_rrdy, b_vld, b_busy;
   logic [255:0] b_dout;

   int n_cmp = 0;
   int n_bad = 0;

   gsim_mat_mem_server #(.DEPTH(544), .RD_LAT(2), .STALL_PERIOD(0)) u_dut (
      .i_clk(clk), .i_reset(rst), .i_ld_mode(ld_mode), .i_ld_wen(ld_wen),
      .i_ld_addr(ld_addr), .i_ld_data(ld_data), .o_ld_err(ld_err),
      .i_mem_rreq(rreq), .i_mem_addr(maddr), .o_mem_rrdy(rrdy),
      .o_mem_dout(dout), .o_mem_dout_vld(vld), .o_busy(busy)
   );

   gsim_mat_mem_server #(.DEPTH(544), .RD_LAT(2), .STALL_PERIOD(4)) u_dut_stall (
      .i_clk(clk), .i_reset(b_rst), .i_ld_mode(b_ld_mode), .i_ld_wen(b_ld_wen),
      .i_ld_addr(b_ld_addr), .i_ld_data(b_ld_data), .o_ld_err(b_ld_err),
      .i_mem_rreq(b_rreq), .i_mem_addr(b_maddr), .o_mem_rrdy(b_rrdy),
      .o_mem_dout(b_dout), .o_mem_dout_vld(b_vld), .o_busy(b_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] w0(input int r);
      return (r == 0) ? 32'h0001_0001 : (32'hC0DE_0000 | 32'(r));
   endfunction

   task automatic wr_a(input logic [9:0] row, input logic [2:0] word, input logic [31:0] data,
                       output logic err);
      ld_wen  = 1'b1;
      ld_addr = {row, word};
      ld_data = data;
      @(negedge clk);
      err     = ld_err;
      ld_wen  = 1'b0;
   endtask

   task automatic wr_b(input logic [9:0] row, input logic [2:0] word, input logic [31:0] data);
      b_ld_wen  = 1'b1;
      b_ld_addr = {row, word};
      b_ld_data = data;
      @(negedge clk);
      b_ld_wen  = 1'b0;
   endtask

   initial begin
      logic         e;
      logic [255:0] row0_exp;
      int           first, last, got, issued, extra;

      for (int w = 0; w < 8; w++)
         row0_exp[32*w +: 32] = 32'h0001_0001 * 32'(w + 1);

      rst = 1'b1; ld_mode = 1'b1; ld_wen = 1'b0; ld_addr = '0; ld_data = '0;
      rreq = 1'b0; maddr = '0;
      b_rst = 1'b1; b_ld_mode = 1'b1; b_ld_wen = 1'b0; b_ld_addr = '0; b_ld_data = '0;
      b_rreq = 1'b0; b_maddr = '0;
      repeat (2) @(negedge clk);

      check_val("rst_rrdy", rrdy, 0);
      check_val("rst_vld", vld, 0);
      check_val("rst_dout", dout, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_ld_err", ld_err, 0);
      rst = 1'b0; b_rst = 1'b0;
      @(negedge clk);

      for (int w = 0; w < 8; w++) begin
         wr_a(10'd0, 3'(w), 32'h0001_0001 * 32'(w + 1), e);
         check_val($sformatf("ld_ok_w%0d", w), e, 0);
      end
      for (int r = 1; r <= 16; r++)
         wr_a(10'(r), 3'd0, w0(r), e);

      // write presented in the mode-switch cycle must be rejected
      ld_mode = 1'b0; ld_wen = 1'b1; ld_addr = {10'd3, 3'd0}; ld_data = 32'hBAD0_BAD0;
      @(negedge clk);
      check_val("ld_err_mode_switch", ld_err, 1);
      ld_wen = 1'b0;
      check_val("rrdy_serve", rrdy, 1);

      // single read: valid exactly two cycles after acceptance
      rreq = 1'b1; maddr = 10'd0;
      @(negedge clk);
      rreq = 1'b0;
      check_val("vld_lat1", vld, 0);
      check_val("busy_inflight", busy, 1);
      @(negedge clk);
      check_val("vld_lat2", vld, 1);
      check_val("row0_lanes", dout, row0_exp);
      @(negedge clk);
      check_val("vld_after", vld, 0);
      check_val("dout_hold", dout, row0_exp);
      check_val("busy_idle", busy, 0);

      // back-to-back rows 0..16 with request held high
      first = -1; last = -1; got = 0; issued = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (vld) begin
            check_val($sformatf("b2b_row%0d", got), dout[31:0], w0(got));
            if (first < 0) first = c;
            last = c;
            got++;
         end
         if (issued < 17) begin
            rreq = 1'b1; maddr = 10'(issued); issued++;
         end else begin
            rreq = 1'b0;
         end
      end
      check_val("b2b_count", got, 17);
      check_val("b2b_no_gaps", last - first, 16);

      // out-of-range row reads back as zero
      rreq = 1'b1; maddr = 10'd600;
      @(negedge clk);
      rreq = 1'b0;
      @(negedge clk);
      check_val("oor_vld", vld, 1);
      check_val("oor_zero", dout, 0);
      @(negedge clk);

      // leave SERVE with two reads in flight
      rreq = 1'b1; maddr = 10'd1;
      @(negedge clk);
      maddr = 10'd2;
      @(negedge clk);
      ld_mode = 1'b1; maddr = 10'd3;
      #1;
      check_val("rrdy_drain_now", rrdy, 0);
      check_val("drain_vld1", vld, 1);
      check_val("drain_dat1", dout[31:0], w0(1));
      check_val("drain_busy", busy, 1);
      @(negedge clk);
      check_val("drain_vld2", vld, 1);
      check_val("drain_dat2", dout[31:0], w0(2));
      ld_wen = 1'b1; ld_addr = {10'd1, 3'd0}; ld_data = 32'hDEAD_BEEF;
      @(negedge clk);
      check_val("ld_err_drain", ld_err, 1);
      check_val("busy_drop", busy, 0);
      ld_wen = 1'b0;
      extra = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (vld) extra++;
      end
      check_val("drain_no_extra_vld", extra, 0);
      rreq = 1'b0;

      wr_a(10'd544, 3'd0, 32'h5555_5555, e);
      check_val("ld_err_oor_row", e, 1);
      wr_a(10'd17, 3'd0, 32'h1717_1717, e);
      check_val("ld_ok_row17", e, 0);

      ld_mode = 1'b0;
      @(negedge clk);
      rreq = 1'b1; maddr = 10'd1;
      @(negedge clk);
      maddr = 10'd17;
      @(negedge clk);
      rreq = 1'b0;
      check_val("row1_unchanged", dout[31:0], w0(1));
      @(negedge clk);
      check_val("row17_loaded", dout[31:0], 32'h1717_1717);

      // reset with two reads in flight
      rreq = 1'b1; maddr = 10'd16;
      @(negedge clk);
      maddr = 10'd0;
      @(negedge clk);
      rreq = 1'b0;
      #1 rst = 1'b1;
      #1;
      check_val("rst_flight_vld", vld, 0);
      check_val("rst_flight_busy", busy, 0);
      check_val("rst_flight_dout", dout, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      extra = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (vld) extra++;
      end
      check_val("no_late_vld", extra, 0);
      rreq = 1'b1; maddr = 10'd16;
      @(negedge clk);
      maddr = 10'd0;
      @(negedge clk);
      rreq = 1'b0;
      check_val("post_rst_row16", dout[31:0], w0(16));
      @(negedge clk);
      check_val("post_rst_row0", dout, row0_exp);

      // bubble cadence with STALL_PERIOD=4
      for (int r = 0; r < 12; r++)
         wr_b(10'(r), 3'd0, 32'hB000_0000 + 32'(r));
      b_ld_mode = 1'b0;
      got = 0; issued = 0;
      for (int s = 1; s <= 30; s++) begin
         @(negedge clk);
         if (s <= 14)
            check_val($sformatf("b_rrdy_s%0d", s), b_rrdy, ((s == 5) || (s == 10)) ? 0 : 1);
         if (b_vld) begin
            check_val($sformatf("b_row%0d", got), b_dout[31:0], 32'hB000_0000 + 32'(got));
            got++;
         end
         if (issued < 12) begin
            b_rreq = 1'b1; b_maddr = 10'(issued);
            if (b_rrdy) issued++;
         end else begin
            b_rreq = 1'b0;
         end
      end
      check_val("b_vld_count", got, 12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/gsim_mat_mem_server.md
GSIM_MAT_MEM_SERVER -- requirements
Module: gsim_mat_mem_server

Interface
REQ-001 Parameter DEPTH, default 544, meaning number of 256-bit rows stored (32 matrices x 17 rows).
REQ-002 Parameter RD_LAT, default 2, meaning cycles from read acceptance to data valid; legal range 1..4.
REQ-003 Parameter STALL_PERIOD, default 0, meaning insert one o_mem_rrdy bubble after every STALL_PERIOD accepted reads; 0 disables bubbles.
REQ-004 i_clk  input  1  clock, all state on rising edge.
REQ-005 i_reset  input  1  asynchronous, active-high reset.
REQ-006 i_ld_mode  input  1  host level request: 1 = load phase, 0 = serve phase.
REQ-007 i_ld_wen  input  1  host write strobe, one 32-bit word per cycle.
REQ-008 i_ld_addr  input  13  host word address {row[12:3], word[2:0]}.
REQ-009 i_ld_data  input  32  host write data.
REQ-010 o_ld_err  output  1  one-cycle pulse: host write rejected.
REQ-011 i_mem_rreq  input  1  solver read request, may be held high continuously.
REQ-012 i_mem_addr  input  10  solver row address.
REQ-013 o_mem_rrdy  output  1  request accepted this cycle when high together with i_mem_rreq.
REQ-014 o_mem_dout  output  256  row data; 16-bit lane i in bits [16i+15:16i].
REQ-015 o_mem_dout_vld  output  1  o_mem_dout valid this cycle.
REQ-016 o_busy  output  1  high while any accepted read is in flight.

Function
REQ-017 FSM states: LOAD, SERVE, DRAIN; reset state LOAD.
REQ-018 LOAD: o_mem_rrdy=0; i_ld_wen writes i_ld_data to word i_ld_addr[2:0] of row i_ld_addr[12:3], i.e. bits [32w+31:32w].
REQ-019 LOAD -> SERVE on the first cycle with i_ld_mode=0; a write presented in that same cycle is rejected.
REQ-020 SERVE: o_mem_rrdy=1 except in bubble cycles; accept = i_mem_rreq & o_mem_rrdy.
REQ-021 SERVE -> DRAIN when i_ld_mode=1; no new accepts from that cycle on.
REQ-022 DRAIN: o_mem_rrdy=0; in-flight reads complete normally; -> LOAD in the cycle after the in-flight counter reaches 0 (same-cycle DRAIN->LOAD if already 0).
REQ-023 i_ld_wen outside LOAD, or with row >= DEPTH: no write, o_ld_err pulses high the next cycle.
REQ-024 Read accepted at edge t: o_mem_dout_vld=1 with that row's data in the cycle following edge t+RD_LAT-1, i.e. exactly RD_LAT cycles later; fully pipelined, one accept per cycle, order preserved.
REQ-025 Read of row >= DEPTH: accepted, returns all-zero data with o_mem_dout_vld=1 at normal latency.
REQ-026 o_mem_dout holds last valid data when o_mem_dout_vld=0.
REQ-027 Bubbles: accept counter counts accepts in SERVE; when it reaches STALL_PERIOD, o_mem_rrdy=0 for exactly one cycle and counter clears; counter retained across DRAIN/LOAD.
REQ-028 In-flight counter, 3 bits: +1 on accept, -1 on vld, unchanged when both; o_busy = counter != 0.
REQ-029 Storage contents undefined after reset until written; no read-modify-write hazard since writes only in LOAD and reads only in SERVE.

Reset
REQ-030 Asynchronous assertion forces: state LOAD, o_mem_rrdy 0, o_mem_dout_vld 0, o_mem_dout 0, o_ld_err 0, o_busy 0, all counters 0; in-flight reads discarded.
REQ-031 Reset does not clear storage array.
REQ-032 First valid accept possible the first SERVE cycle after reset deassertion and i_ld_mode=0.

Structure
REQ-033 Shared package holds: state encoding (LOAD/SERVE/DRAIN), ROW_W=256, ROWS_PER_MAT=17, MAX_MATS=32.
REQ-034 One sub-module gsim_row_sram: DEPTH x 256 array, 32-bit word write enable, 1-cycle registered read; remaining RD_LAT-1 stages as a valid/data shift pipeline in the top.

Verification
REQ-035 Load row 0 words 0..7 with 0x00010001*(w+1), RD_LAT=2, read addr 0 -> vld exactly 2 cycles after accept, dout lane i = (i/2)+1.
REQ-036 i_mem_rreq held 1, addresses 0..16 back-to-back, STALL_PERIOD=0 -> 17 consecutive vld cycles, in order, no gaps.
REQ-037 STALL_PERIOD=4, 12 requests -> o_mem_rrdy low on cycles 5 and 10 of SERVE, 12 vld total, order preserved.
REQ-038 Raise i_ld_mode with 2 reads in flight -> rrdy 0 immediately, both vld delivered, state LOAD after o_busy drops; i_ld_wen during DRAIN -> o_ld_err pulse, row unchanged.
REQ-039 Read addr 600 (>= DEPTH) -> vld with dout 0; write row 544 -> o_ld_err.
REQ-040 Assert i_reset with 2 reads in flight -> o_mem_dout_vld 0 and o_busy 0 immediately, no late vld; previously loaded rows readable after re-entering SERVE.
